sorted_pkt_stats: RTL and testbench
===================================

# sorted_pkt_stats

Packet statistics stage sitting directly downstream of the packet sorter. It consumes sorted Avalon-ST packets and produces one result record per packet. The record holds the element count, the minimum, the maximum, the sum, and error flags. Results leave on a valid/ready handshake toward the control/report logic.

## Interface
Parameters:
- DWIDTH, 8, data element width (unsigned).
- MAX_PKT_LEN, 1024, maximum legal packet length in beats.
- CNT_W, $clog2(MAX_PKT_LEN+1), count width (localparam).
- SUM_W, DWIDTH+CNT_W, sum width (localparam); the sum cannot overflow for legal packets.

Ports (clock and reset first):
- clk_i  in  1  single clock; all logic on the rising edge.
- srst_i  in  1  reset, asynchronous, active-high.
- snk_data_i  in  DWIDTH  input element.
- snk_startofpacket_i  in  1  first beat of a packet.
- snk_endofpacket_i  in  1  last beat of a packet.
- snk_valid_i  in  1  beat valid.
- snk_ready_o  out  1  sink ready; a beat is accepted when valid && ready.
- res_count_o  out  CNT_W  beats counted in the packet.
- res_min_o  out  DWIDTH  minimum element.
- res_max_o  out  DWIDTH  maximum element.
- res_sum_o  out  SUM_W  unsigned sum of counted elements.
- res_order_err_o  out  1  packet was not non-decreasing.
- res_framing_err_o  out  1  framing or length violation seen in this packet.
- res_valid_o  out  1  result record valid.
- res_ready_i  in  1  result consumer ready.

## Operation
- FSM states are IDLE, ACCUM and RESULT. Reset puts the FSM in IDLE.
- snk_ready_o = (state != RESULT), decoded from the state register only. There is no combinational path from any input.
- IDLE:
  - An accepted beat without sop is discarded silently; stats are unchanged.
  - An accepted sop beat loads count=1, min=max=sum=prev=data, and clears both error flags.
  - If that beat also has eop, go to RESULT. Otherwise go to ACCUM.
- ACCUM, accepted beat without sop:
  - If count < MAX_PKT_LEN: count+1, sum+=data, min=min(min,data), max=max(max,data), prev=data.
  - If data < prev: set order_err.
  - If count == MAX_PKT_LEN: the beat is not counted; set framing_err.
  - If the beat has eop: go to RESULT.
- ACCUM, accepted beat with sop: set framing_err and restart accumulation with this beat, as in IDLE. framing_err stays set for the new packet.
- RESULT:
  - res_valid_o=1. All res_* outputs are held stable.
  - On res_valid_o && res_ready_i, go to IDLE.
- All comparisons are unsigned.

## Timing
- Reset values: snk_ready_o=1, res_valid_o=0, all res_* data and flag outputs 0.
- Latency: res_valid_o rises in the cycle after the eop beat is accepted.
- snk_ready_o falls in the same cycle that res_valid_o rises.
- Minimum RESULT dwell is 1 cycle when res_ready_i=1. Peak throughput is one idle sink cycle per packet.
- Results are registered outputs. Their values change only when the FSM enters RESULT.
- If res_ready_i is held low, RESULT holds indefinitely and the sink stays back-pressured.
- The sink accepts one beat per cycle while in IDLE or ACCUM.
- A single-beat packet (sop and eop together) gives count=1, min=max=sum=data.
- Asynchronous reset mid-packet or mid-RESULT abandons everything immediately: FSM to IDLE, outputs to reset values. No partial record is emitted.
- The FSM ignores snk_valid_i entirely in RESULT; upstream must hold the beat.

## Configuration
- Macro: SORTED_PKT_STATS_ORDER_CHECK_EN.
- Defined: the prev register and comparator are built, and res_order_err_o reports non-decreasing violations as specified.
- Undefined: the prev register and comparator are removed and res_order_err_o is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then sop+eop single beat 0x5A -> next cycle res_valid_o=1, count=1, min=max=0x5A, sum=0x5A, both errors 0.
- Packet 1,2,2,9 with res_ready_i=1 -> count=4, min=1, max=9, sum=14, order_err=0. snk_ready_o is low for exactly 1 cycle.
- Packet 3,7,5 -> order_err=1 (0 when the macro is undefined), min=3, max=7, sum=15.
- Packet 4,6 then a new sop with 2,8,eop (no eop before it) -> one record: count=2, min=2, max=8, sum=10, framing_err=1.
- MAX_PKT_LEN=4, packet of 6 beats all 0xFF -> count=4, sum=0x3FC, framing_err=1. Also hold res_ready_i=0 for 10 cycles -> outputs stable and snk_ready_o=0 throughout.
- Assert srst_i mid-packet after 3 beats -> no record is emitted. A following packet 0x10 (sop+eop) gives count=1, sum=0x10.

Source files
------------

// File: rtl/sorted_pkt_stats.sv
// sorted_pkt_stats: per-packet statistics (count, min, max, sum, error flags)
// for sorted Avalon-ST packets, with a valid/ready result record.
// Optional macro SORTED_PKT_STATS_ORDER_CHECK_EN builds the non-decreasing
// order checker; without it res_order_err_o is constant 0.
module sorted_pkt_stats #(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned MAX_PKT_LEN = 1024,
  localparam int unsigned CNT_W      = $clog2(MAX_PKT_LEN + 1),
  localparam int unsigned SUM_W      = DWIDTH + CNT_W
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [CNT_W-1:0]  res_count_o,
  output logic [DWIDTH-1:0] res_min_o,
  output logic [DWIDTH-1:0] res_max_o,
  output logic [SUM_W-1:0]  res_sum_o,
  output logic              res_order_err_o,
  output logic              res_framing_err_o,
  output logic              res_valid_o,
  input  logic              res_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_RESULT} state_e;

  state_e            state_q;
  logic              ready_q;
  logic              beat;
  logic              counted;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DWIDTH-1:0] min_q, min_d;
  logic [DWIDTH-1:0] max_q, max_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              ord_q, ord_d;
  logic              frm_q, frm_d;
`ifdef SORTED_PKT_STATS_ORDER_CHECK_EN
  logic [DWIDTH-1:0] prev_q, prev_d;
`endif

  logic [CNT_W-1:0]  res_cnt_q;
  logic [DWIDTH-1:0] res_min_q;
  logic [DWIDTH-1:0] res_max_q;
  logic [SUM_W-1:0]  res_sum_q;
  logic              res_ord_q;
  logic              res_frm_q;
  logic              res_valid_q;

  assign beat    = snk_valid_i & ready_q;
  assign counted = (cnt_q < CNT_W'(MAX_PKT_LEN));

  // Accumulator next values for the beat accepted this cycle (holds otherwise)
  always_comb begin
    cnt_d = cnt_q;
    min_d = min_q;
    max_d = max_q;
    sum_d = sum_q;
    ord_d = ord_q;
    frm_d = frm_q;
`ifdef SORTED_PKT_STATS_ORDER_CHECK_EN
    prev_d = prev_q;
`endif
    if (beat) begin
      if (snk_startofpacket_i) begin
        // New packet; a sop while still accumulating is a framing error
        cnt_d = CNT_W'(1);
        min_d = snk_data_i;
        max_d = snk_data_i;
        sum_d = SUM_W'(snk_data_i);
        ord_d = 1'b0;
        frm_d = (state_q == S_ACCUM);
`ifdef SORTED_PKT_STATS_ORDER_CHECK_EN
        prev_d = snk_data_i;
`endif
      end else if (state_q == S_ACCUM) begin
        if (counted) begin
          cnt_d = cnt_q + CNT_W'(1);
          sum_d = sum_q + SUM_W'(snk_data_i);
          if (snk_data_i < min_q) min_d = snk_data_i;
          if (snk_data_i > max_q) max_d = snk_data_i;
`ifdef SORTED_PKT_STATS_ORDER_CHECK_EN
          prev_d = snk_data_i;
`endif
        end else begin
          frm_d = 1'b1;
        end
`ifdef SORTED_PKT_STATS_ORDER_CHECK_EN
        if (snk_data_i < prev_q) ord_d = 1'b1;
`endif
      end
    end
  end

  // Control FSM, accumulator registers and registered result record
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      cnt_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      sum_q       <= '0;
      ord_q       <= 1'b0;
      frm_q       <= 1'b0;
`ifdef SORTED_PKT_STATS_ORDER_CHECK_EN
      prev_q      <= '0;
`endif
      res_cnt_q   <= '0;
      res_min_q   <= '0;
      res_max_q   <= '0;
      res_sum_q   <= '0;
      res_ord_q   <= 1'b0;
      res_frm_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      min_q <= min_d;
      max_q <= max_d;
      sum_q <= sum_d;
      ord_q <= ord_d;
      frm_q <= frm_d;
`ifdef SORTED_PKT_STATS_ORDER_CHECK_EN
      prev_q <= prev_d;
`endif
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (beat && (snk_startofpacket_i || state_q == S_ACCUM)) begin
            if (snk_endofpacket_i) begin
              state_q     <= S_RESULT;
              ready_q     <= 1'b0;
              res_valid_q <= 1'b1;
              res_cnt_q   <= cnt_d;
              res_min_q   <= min_d;
              res_max_q   <= max_d;
              res_sum_q   <= sum_d;
              res_ord_q   <= ord_d;
              res_frm_q   <= frm_d;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_RESULT: begin
          if (res_ready_i) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          ready_q     <= 1'b1;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign snk_ready_o       = ready_q;
  assign res_count_o       = res_cnt_q;
  assign res_min_o         = res_min_q;
  assign res_max_o         = res_max_q;
  assign res_sum_o         = res_sum_q;
  assign res_order_err_o   = res_ord_q;
  assign res_framing_err_o = res_frm_q;
  assign res_valid_o       = res_valid_q;

endmodule

// File: tb/tb_sorted_pkt_stats.sv
// tb_sorted_pkt_stats: directed and randomized checks of sorted_pkt_stats
// against a packet-level reference model (MAX_PKT_LEN = 4).
module tb_sorted_pkt_stats;

  localparam int unsigned DW    = 8;
  localparam int unsigned MAXL  = 4;
  localparam int unsigned CW    = $clog2(MAXL + 1);
  localparam int unsigned SW    = DW + CW;
`ifdef SORTED_PKT_STATS_ORDER_CHECK_EN
  localparam bit ORD_EN = 1'b1;
`else
  localparam bit ORD_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          srst_i;
  logic [DW-1:0] snk_data_i;
  logic          snk_startofpacket_i;
  logic          snk_endofpacket_i;
  logic          snk_valid_i;
  logic          snk_ready_o;
  logic [CW-1:0] res_count_o;
  logic [DW-1:0] res_min_o;
  logic [DW-1:0] res_max_o;
  logic [SW-1:0] res_sum_o;
  logic          res_order_err_o;
  logic          res_framing_err_o;
  logic          res_valid_o;
  logic          res_ready_i;

  sorted_pkt_stats #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i(clk_i), .srst_i(srst_i),
    .snk_data_i(snk_data_i), .snk_startofpacket_i(snk_startofpacket_i),
    .snk_endofpacket_i(snk_endofpacket_i), .snk_valid_i(snk_valid_i),
    .snk_ready_o(snk_ready_o),
    .res_count_o(res_count_o), .res_min_o(res_min_o), .res_max_o(res_max_o),
    .res_sum_o(res_sum_o), .res_order_err_o(res_order_err_o),
    .res_framing_err_o(res_framing_err_o), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int tests  = 0;
  int failed = 0;

  // Reference model: collects the current packet's elements, scores at eop
  int unsigned pkt[$];
  bit          in_pkt  = 1'b0;
  bit          m_frm   = 1'b0;
  int unsigned e_cnt, e_min, e_max, e_sum;
  bit          e_ord, e_frm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_finish();
    int unsigned n;
    n     = pkt.size();
    e_cnt = (n > MAXL) ? MAXL : n;
    e_frm = m_frm || (n > MAXL);
    e_sum = 0;
    e_min = 255;
    e_max = 0;
    for (int i = 0; i < int'(e_cnt); i++) begin
      e_sum += pkt[i];
      if (pkt[i] < e_min) e_min = pkt[i];
      if (pkt[i] > e_max) e_max = pkt[i];
    end
    e_ord = 1'b0;
    if (ORD_EN) begin
      // Beats past the length limit are compared with the last counted one
      for (int i = 1; i < int'(n); i++) begin
        int r;
        r = (i - 1 < int'(MAXL) - 1) ? i - 1 : int'(MAXL) - 1;
        if (pkt[i] < pkt[r]) e_ord = 1'b1;
      end
    end
  endtask

  task automatic model_beat(input int unsigned d, input bit sop, input bit eop);
    if (sop) begin
      m_frm  = in_pkt;
      pkt.delete();
      pkt.push_back(d);
      in_pkt = 1'b1;
    end else if (in_pkt) begin
      pkt.push_back(d);
    end else begin
      return;
    end
    if (eop) begin
      model_finish();
      in_pkt = 1'b0;
    end
  endtask

  task automatic send_beat(input int unsigned d, input bit sop, input bit eop);
    int n;
    @(negedge clk_i);
    snk_data_i          = DW'(d);
    snk_startofpacket_i = sop;
    snk_endofpacket_i   = eop;
    snk_valid_i         = 1'b1;
    n = 0;
    while (!snk_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n == 100) begin
      failed++;
      $error("FAIL sink_ready_timeout: observed 0 expected 1");
    end
    @(posedge clk_i);
    model_beat(d, sop, eop);
  endtask

  task automatic idle_cycle();
    @(negedge clk_i);
    snk_valid_i = 1'b0;
  endtask

  task automatic chk_record(input string tag);
    chk({tag, "_valid"}, 64'(res_valid_o), 64'(1));
    chk({tag, "_ready"}, 64'(snk_ready_o), 64'(0));
    chk({tag, "_count"}, 64'(res_count_o), 64'(e_cnt));
    chk({tag, "_min"},   64'(res_min_o),   64'(e_min));
    chk({tag, "_max"},   64'(res_max_o),   64'(e_max));
    chk({tag, "_sum"},   64'(res_sum_o),   64'(e_sum));
    chk({tag, "_ord"},   64'(res_order_err_o),   64'(e_ord));
    chk({tag, "_frm"},   64'(res_framing_err_o), 64'(e_frm));
  endtask

  // Checks the record one cycle after eop; with res_ready_i high, also
  // checks that the sink stalls for exactly that one cycle.
  task automatic expect_result(input string tag);
    @(negedge clk_i);
    snk_valid_i = 1'b0;
    chk_record(tag);
    if (res_ready_i) begin
      @(negedge clk_i);
      chk({tag, "_post_valid"}, 64'(res_valid_o), 64'(0));
      chk({tag, "_post_ready"}, 64'(snk_ready_o), 64'(1));
    end
  endtask

  task automatic send_pkt(input int unsigned d[$]);
    for (int i = 0; i < d.size(); i++)
      send_beat(d[i], i == 0, i == d.size() - 1);
  endtask

  initial begin
    int unsigned q[$];
    srst_i = 1'b1;
    snk_data_i = '0; snk_startofpacket_i = 1'b0; snk_endofpacket_i = 1'b0;
    snk_valid_i = 1'b0; res_ready_i = 1'b1;
    #12;
    chk("rst_ready", 64'(snk_ready_o), 64'(1));
    chk("rst_valid", 64'(res_valid_o), 64'(0));
    chk("rst_count", 64'(res_count_o), 64'(0));
    chk("rst_sum",   64'({res_min_o, res_max_o, res_sum_o}), 64'(0));
    chk("rst_flags", 64'({res_order_err_o, res_framing_err_o}), 64'(0));
    @(negedge clk_i);
    srst_i = 1'b0;

    // Single-beat packet
    send_beat(32'h5A, 1, 1);
    expect_result("single");
    chk("single_exp_cnt", 64'(res_count_o), 64'(1));

    // Stray beat in IDLE is discarded, then a sorted packet
    send_beat(32'h77, 0, 1);
    q = '{1, 2, 2, 9};
    send_pkt(q);
    expect_result("sorted");

    // Unsorted packet
    q = '{3, 7, 5};
    send_pkt(q);
    expect_result("unsorted");

    // sop inside an open packet restarts with framing error
    send_beat(4, 1, 0);
    send_beat(6, 0, 0);
    send_beat(2, 1, 0);
    send_beat(8, 0, 1);
    expect_result("restart");

    // Over-length packet, then hold the record with res_ready_i low
    res_ready_i = 1'b0;
    q = '{255, 255, 255, 255, 255, 255};
    send_pkt(q);
    expect_result("overlen");
    snk_data_i = 8'h33; snk_startofpacket_i = 1'b1;
    snk_endofpacket_i = 1'b1; snk_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk_record("hold");
    end
    res_ready_i = 1'b1;
    send_beat(32'h33, 1, 1);
    expect_result("held_beat");

    // Reset in the middle of a packet
    send_beat(32'h20, 1, 0);
    send_beat(32'h21, 0, 0);
    send_beat(32'h22, 0, 0);
    @(negedge clk_i);
    snk_valid_i = 1'b0;
    srst_i = 1'b1;
    #1;
    chk("midrst_valid", 64'(res_valid_o), 64'(0));
    chk("midrst_ready", 64'(snk_ready_o), 64'(1));
    chk("midrst_count", 64'(res_count_o), 64'(0));
    in_pkt = 1'b0;
    @(negedge clk_i);
    srst_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      chk("midrst_norecord", 64'(res_valid_o), 64'(0));
    end
    send_beat(32'h10, 1, 1);
    expect_result("after_rst");

    // Randomized packets
    for (int p = 0; p < 60; p++) begin
      int unsigned len, base;
      bit sorted;
      res_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) send_beat($urandom_range(0, 255), 0, $urandom_range(0, 1));
      len    = $urandom_range(1, 7);
      sorted = $urandom_range(0, 1);
      base   = $urandom_range(0, 200);
      for (int i = 0; i < int'(len); i++) begin
        int unsigned d;
        bit sop;
        d   = sorted ? ((base + 8 * i > 255) ? 255 : base + 8 * i) : $urandom_range(0, 255);
        sop = (i == 0) || ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 3) == 0) idle_cycle();
        send_beat(d, sop, i == int'(len) - 1);
      end
      expect_result("rand");
      if (!res_ready_i) begin
        repeat ($urandom_range(1, 4)) begin
          @(negedge clk_i);
          chk("rand_hold_valid", 64'(res_valid_o), 64'(1));
          chk("rand_hold_sum",   64'(res_sum_o),   64'(e_sum));
        end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        chk("rand_release", 64'({res_valid_o, snk_ready_o}), 64'(1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
